alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter SHALL be: WIDTH, 8, operand width in bits (result width 2*WIDTH).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  bit i = requester i presents an operation.
REQ-005 req_ready  output  2  bit i = operation of requester i is accepted this cycle.
REQ-006 req_op  input  2  bit i: 0 = add, 1 = multiply.
REQ-007 req_a  input  2*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  2*WIDTH  operand B; same packing as req_a.
REQ-009 rsp_valid  output  1  result valid, single-cycle pulse, no backpressure.
REQ-010 rsp_id  output  1  requester index owning the result.
REQ-011 rsp_data  output  2*WIDTH  unsigned result, zero-extended.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM SHALL have states IDLE, EXEC, RESP; all outputs registered except req_ready.
REQ-014 req_ready SHALL be combinational, asserted only in IDLE, at most one bit high, only for the granted valid requester.
REQ-015 Transfer occurs on the edge where req_valid[g] and req_ready[g] are both high; operands, op and g SHALL be captured; IDLE -> EXEC.
REQ-016 A requester SHALL hold valid and operands stable until accepted; deasserting before acceptance withdraws the request.
REQ-017 Add: EXEC SHALL last 1 cycle; result = a + b, WIDTH+1 bits, zero-extended.
REQ-018 Multiply: EXEC SHALL last WIDTH cycles, one shift-add step per cycle (LSB-first on b); result = a * b exact in 2*WIDTH bits.
REQ-019 EXEC -> RESP after the last step; rsp_valid high exactly one cycle in RESP with rsp_id = g, rsp_data = result; RESP -> IDLE.
REQ-020 Latency from accept edge N: add rsp_valid in cycle N+2; multiply in cycle N+WIDTH+1 (N+9 for WIDTH=8).
REQ-021 No request SHALL be accepted outside IDLE; next accept earliest the cycle after RESP.
REQ-022 rsp_data and rsp_id SHALL hold last response value when rsp_valid is low.
REQ-023 Only one requester valid: that requester is granted regardless of arbitration pointer.
REQ-024 Operand zero on multiply SHALL still take full WIDTH cycles (fixed latency).

Reset
REQ-025 rst SHALL force state IDLE, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, arbitration pointer to favour requester 0, step counter 0.
REQ-026 rst during EXEC or RESP SHALL abort the operation; no rsp_valid for it is ever issued.
REQ-027 req_ready SHALL be 0 in any cycle rst is high.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: both valid in IDLE -> grant the requester not granted last; pointer updates on every accept.
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins when both valid; no pointer register.

Verification
REQ-030 Req0 add a=255,b=255 alone -> req_ready=01 at accept, rsp_valid at N+2, rsp_id=0, rsp_data=510.
REQ-031 Req1 mul a=255,b=255, WIDTH=8 -> rsp_valid at N+9, rsp_id=1, rsp_data=65025, busy high N+1..N+9.
REQ-032 Both valid continuously, add 10+99 (req0) and 33+1 (req1) -> RR build: grants 0,1,0,1, results 109,34 alternating; fixed build: only req0 granted.
REQ-033 Req0 mul a=0,b=99 -> rsp_data=0 at N+9 (full latency).
REQ-034 rst asserted at N+4 of mul 12*12 -> no rsp_valid, busy 0 next cycle, next grant to req0.
REQ-035 Req1 valid during EXEC of req0 operation -> req_ready stays 00 until IDLE; req1 accepted cycle after RESP.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared add / shift-add multiply unit.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is only offered in IDLE and never
  // while rst is high. Responses are single-cycle pulses without backpressure.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic               op_q;
  logic               id_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic [1:0]         grant;
  logic               accept;
  logic               gid;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // On contention, grant whichever requester was not granted last.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11)
      grant = last_q ? 2'b01 : 2'b10;
    else if (req_valid[0])
      grant = 2'b01;
    else if (req_valid[1])
      grant = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b1;
    else if (accept)
      last_q <= gid;
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req_valid[0])
      grant = 2'b01;
    else if (req_valid[1])
      grant = 2'b10;
  end
`endif

  assign req_ready = (state_q == IDLE && !rst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gid       = req_ready[1];
  assign a_sel     = gid ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign b_sel     = gid ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  // Add reuses the operand registers: a sits in the low half of mcand_q.
  assign sum      = {1'b0, mcand_q[WIDTH-1:0]} + {1'b0, mplier_q};
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      id_q      <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            op_q     <= req_op[gid];
            id_q     <= gid;
            mcand_q  <= {{WIDTH{1'b0}}, a_sel};
            mplier_q <= b_sel;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (!op_q) begin
            rsp_data  <= {{(WIDTH-1){1'b0}}, sum};
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            // One LSB-first shift-add step per cycle; fixed WIDTH steps.
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
              rsp_data  <= acc_next;
              rsp_id    <= id_q;
              rsp_valid <= 1'b1;
              state_q   <= RESP;
            end
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (WIDTH=8), one task per scenario.
// Arbitration expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_alu_share_arbiter;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     req_op;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_id;
  logic [2*W-1:0] rsp_data;
  logic           busy;
  logic [1:0]     dbg_state;

  int pass_cnt;
  int total_cnt;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_valid = 2'b11;
    step();
    step();
    #1;
    total_cnt++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_id !== 1'b0 || rsp_data !== 16'd0)
      $display("FAIL reset_rsp: got id %b data %0d expected id 0 data 0", rsp_id, rsp_data);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else pass_cnt++;
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_add_single();
    req_valid = 2'b01;
    req_op    = 2'b00;
    req_a     = {8'd0, 8'd255};
    req_b     = {8'd0, 8'd255};
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL add_ready: got %b expected 01", req_ready);
    else pass_cnt++;
    step();
    idle_inputs();
    total_cnt++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL add_n1: got busy %b rsp_valid %b expected 1 0", busy, rsp_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'd510)
      $display("FAIL add_rsp: got v %b id %b data %0d expected 1 0 510", rsp_valid, rsp_id, rsp_data);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'd510 || busy !== 1'b0)
      $display("FAIL add_hold: got v %b data %0d busy %b expected 0 510 0", rsp_valid, rsp_data, busy);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    req_valid = 2'b10;
    req_op    = 2'b10;
    req_a     = {8'd255, 8'd0};
    req_b     = {8'd255, 8'd0};
    #1;
    total_cnt++;
    if (req_ready !== 2'b10) $display("FAIL mul_ready: got %b expected 10", req_ready);
    else pass_cnt++;
    step();
    idle_inputs();
    for (int k = 1; k <= 9; k++) begin
      total_cnt++;
      if (busy !== 1'b1 || rsp_valid !== (k == 9))
        $display("FAIL mul_cycle%0d: got busy %b v %b expected 1 %0d", k, busy, rsp_valid, (k == 9));
      else pass_cnt++;
      if (k == 9) begin
        total_cnt++;
        if (rsp_id !== 1'b1 || rsp_data !== 16'd65025)
          $display("FAIL mul_rsp: got id %b data %0d expected 1 65025", rsp_id, rsp_data);
        else pass_cnt++;
      end
      if (k < 9) step();
    end
    step();
    total_cnt++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL mul_done: got busy %b v %b expected 0 0", busy, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_mul_zero();
    req_valid = 2'b01;
    req_op    = 2'b01;
    req_a     = {8'd0, 8'd0};
    req_b     = {8'd0, 8'd99};
    #1;
    step();
    idle_inputs();
    for (int k = 1; k <= 9; k++) begin
      total_cnt++;
      if (rsp_valid !== (k == 9))
        $display("FAIL mulzero_cycle%0d: got v %b expected %0d", k, rsp_valid, (k == 9));
      else pass_cnt++;
      if (k < 9) step();
    end
    total_cnt++;
    if (rsp_data !== 16'd0 || rsp_id !== 1'b0)
      $display("FAIL mulzero_rsp: got id %b data %0d expected 0 0", rsp_id, rsp_data);
    else pass_cnt++;
    step();
  endtask

  task automatic test_rst_abort();
    bit seen;
    req_valid = 2'b01;
    req_op    = 2'b01;
    req_a     = {8'd0, 8'd12};
    req_b     = {8'd0, 8'd12};
    #1;
    step();
    idle_inputs();
    repeat (3) step();
    rst = 1'b1;
    step();
    total_cnt++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL abort_busy: got busy %b v %b expected 0 0", busy, rsp_valid);
    else pass_cnt++;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL abort_no_rsp: got rsp_valid 1 expected 0");
    else pass_cnt++;
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01) $display("FAIL abort_next_grant: got %b expected 01", req_ready);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_arbitration();
    logic [1:0]     exp_g;
    logic [2*W-1:0] exp_d;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 2'b11;
    req_op    = 2'b00;
    req_a     = {8'd33, 8'd10};
    req_b     = {8'd1, 8'd99};
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      exp_d = (exp_g == 2'b01) ? 16'd109 : 16'd34;
      #1;
      total_cnt++;
      if (req_ready !== exp_g) $display("FAIL arb_grant%0d: got %b expected %b", i, req_ready, exp_g);
      else pass_cnt++;
      step();
      total_cnt++;
      if (req_ready !== 2'b00) $display("FAIL arb_exec_ready%0d: got %b expected 00", i, req_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_g[1] || rsp_data !== exp_d)
        $display("FAIL arb_rsp%0d: got v %b id %b data %0d expected 1 %b %0d",
                 i, rsp_valid, rsp_id, rsp_data, exp_g[1], exp_d);
      else pass_cnt++;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    req_valid = 2'b01;
    req_op    = 2'b01;
    req_a     = {8'd0, 8'd3};
    req_b     = {8'd0, 8'd5};
    #1;
    step();
    req_valid = 2'b10;
    req_op    = 2'b00;
    req_a     = {8'd7, 8'd0};
    req_b     = {8'd9, 8'd0};
    for (int k = 1; k <= 9; k++) begin
      #1;
      total_cnt++;
      if (req_ready !== 2'b00) $display("FAIL b2b_ready_cycle%0d: got %b expected 00", k, req_ready);
      else pass_cnt++;
      if (k < 9) step();
    end
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'd15)
      $display("FAIL b2b_rsp0: got v %b id %b data %0d expected 1 0 15", rsp_valid, rsp_id, rsp_data);
    else pass_cnt++;
    step();
    #1;
    total_cnt++;
    if (req_ready !== 2'b10) $display("FAIL b2b_accept1: got %b expected 10", req_ready);
    else pass_cnt++;
    step();
    idle_inputs();
    step();
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'd16)
      $display("FAIL b2b_rsp1: got v %b id %b data %0d expected 1 1 16", rsp_valid, rsp_id, rsp_data);
    else pass_cnt++;
    step();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    idle_inputs();
    test_reset();
    test_add_single();
    test_mul();
    test_mul_zero();
    test_rst_abort();
    test_arbitration();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
